// File: rtl/exe_stage.sv
// MIPS execute stage: ALU, operand forwarding, iterative multiply, EXE/MEM register.
// Forwarding is compiled in only when EXE_FWD_EN is defined.
module exe_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        validIn,
  input  logic [2:0]  EXE_In,
  input  logic        aluSrcIn,
  input  logic        M_In,
  input  logic [1:0]  WB_In,
  input  logic [4:0]  src1In,
  input  logic [4:0]  src2In,
  input  logic [4:0]  dstIn,
  input  logic [31:0] readData1In,
  input  logic [31:0] readData2In,
  input  logic [31:0] signExIn,
  input  logic [31:0] PC_In,
  input  logic        wbWe,
  input  logic [4:0]  wbDst,
  input  logic [31:0] wbData,
  output logic        stall,
  output logic        validOut,
  output logic        M_Out,
  output logic [1:0]  WB_Out,
  output logic [4:0]  dstOut,
  output logic [31:0] aluResOut,
  output logic [31:0] storeDataOut,
  output logic [31:0] PC_Out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} st_e;

  // bits of multiplier consumed per iteration so any MUL_CYCLES covers 32 bits
  localparam int STEP = (32 + MUL_CYCLES - 1) / MUL_CYCLES;
  localparam logic [4:0] LAST = 5'(MUL_CYCLES - 1);

  st_e         st_q, st_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] mc_q, mc_d;
  logic [31:0] mp_q, mp_d;
  logic [31:0] prod_q, prod_d;
  logic [31:0] sd_q, sd_d;

  logic [31:0] opa, opb_r, opb, alu, part;
  logic        is_mul;

  assign is_mul = (EXE_In == 3'b111);

`ifdef EXE_FWD_EN
  logic exm_ok;
  assign exm_ok = validOut & WB_Out[1] & ~WB_Out[0];

  always_comb begin
    opa   = readData1In;
    opb_r = readData2In;
    if (src1In != 5'd0 && exm_ok && dstOut == src1In)
      opa = aluResOut;
    else if (src1In != 5'd0 && wbWe && wbDst == src1In)
      opa = wbData;
    if (src2In != 5'd0 && exm_ok && dstOut == src2In)
      opb_r = aluResOut;
    else if (src2In != 5'd0 && wbWe && wbDst == src2In)
      opb_r = wbData;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{wbWe, wbDst, wbData, src1In, src2In};
  assign opa   = readData1In;
  assign opb_r = readData2In;
`endif

  assign opb = aluSrcIn ? signExIn : opb_r;

  always_comb begin
    alu = '0;
    unique case (EXE_In)
      3'b000: alu = opa + opb;
      3'b001: alu = opa - opb;
      3'b010: alu = opa & opb;
      3'b011: alu = opa | opb;
      3'b100: alu = ~(opa | opb);
      3'b101: alu = {31'd0, $signed(opa) < $signed(opb)};
      3'b110: alu = opa << opb[4:0];
      3'b111: alu = prod_q;
    endcase
  end

  always_comb begin
    part = '0;
    for (int i = 0; i < STEP; i++)
      if (mp_q[i]) part = part + (mc_q << i);
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    mc_d   = mc_q;
    mp_d   = mp_q;
    prod_d = prod_q;
    sd_d   = sd_q;
    unique case (st_q)
      IDLE: begin
        if (validIn && is_mul) begin
          mc_d   = opa;
          mp_d   = opb;
          sd_d   = opb_r;
          prod_d = '0;
          cnt_d  = '0;
          st_d   = BUSY;
        end
      end
      BUSY: begin
        prod_d = prod_q + part;
        mc_d   = mc_q << STEP;
        mp_d   = mp_q >> STEP;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == LAST) st_d = DONE;
      end
      DONE:    st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // reset gates stall so the pipeline is released during reset
  assign stall = rst & validIn & is_mul & (st_q != DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q         <= IDLE;
      cnt_q        <= '0;
      mc_q         <= '0;
      mp_q         <= '0;
      prod_q       <= '0;
      sd_q         <= '0;
      validOut     <= 1'b0;
      M_Out        <= 1'b0;
      WB_Out       <= '0;
      dstOut       <= '0;
      aluResOut    <= '0;
      storeDataOut <= '0;
      PC_Out       <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      mc_q   <= mc_d;
      mp_q   <= mp_d;
      prod_q <= prod_d;
      sd_q   <= sd_d;
      if (stall || !validIn) begin
        validOut     <= 1'b0;
        M_Out        <= 1'b0;
        WB_Out       <= '0;
        dstOut       <= '0;
        aluResOut    <= '0;
        storeDataOut <= '0;
        PC_Out       <= '0;
      end else begin
        validOut     <= 1'b1;
        M_Out        <= M_In;
        WB_Out       <= WB_In;
        dstOut       <= dstIn;
        aluResOut    <= alu;
        storeDataOut <= is_mul ? sd_q : opb_r;
        PC_Out       <= PC_In;
      end
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Randomized bench for exe_stage against an arithmetic reference model.
module tb_exe_stage;

  localparam int MC = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        validIn, aluSrcIn, M_In, wbWe;
  logic [2:0]  EXE_In;
  logic [1:0]  WB_In;
  logic [4:0]  src1In, src2In, dstIn, wbDst;
  logic [31:0] readData1In, readData2In, signExIn, PC_In, wbData;
  logic        stall, validOut, M_Out;
  logic [1:0]  WB_Out;
  logic [4:0]  dstOut;
  logic [31:0] aluResOut, storeDataOut, PC_Out;

  int n_cmp = 0;
  int n_bad = 0;

  logic        m_v;
  logic [1:0]  m_wb;
  logic [4:0]  m_dst;
  logic [31:0] m_res;
  logic [31:0] r;

  always #5 clk = ~clk;

  exe_stage #(.MUL_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .validIn(validIn), .EXE_In(EXE_In),
    .aluSrcIn(aluSrcIn), .M_In(M_In), .WB_In(WB_In),
    .src1In(src1In), .src2In(src2In), .dstIn(dstIn),
    .readData1In(readData1In), .readData2In(readData2In),
    .signExIn(signExIn), .PC_In(PC_In),
    .wbWe(wbWe), .wbDst(wbDst), .wbData(wbData),
    .stall(stall), .validOut(validOut), .M_Out(M_Out),
    .WB_Out(WB_Out), .dstOut(dstOut), .aluResOut(aluResOut),
    .storeDataOut(storeDataOut), .PC_Out(PC_Out)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_fwd(input logic [4:0] s,
                                          input logic [31:0] rf);
`ifdef EXE_FWD_EN
    if (s == 0) return rf;
    if (m_v && m_wb == 2'b10 && m_dst == s) return m_res;
    if (wbWe && wbDst == s) return wbData;
`endif
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return ~(a | b);
      5: return (signed'(a) < signed'(b)) ? 32'd1 : 32'd0;
      6: return a << (b % 32);
      default: return 32'((64'(a) * 64'(b)) % 64'h1_0000_0000);
    endcase
  endfunction

  task automatic drive(input logic [2:0] op, input logic as,
                       input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] sx);
    validIn     = 1'b1;
    EXE_In      = op;
    aluSrcIn    = as;
    src1In      = s1;
    src2In      = s2;
    dstIn       = d;
    readData1In = r1;
    readData2In = r2;
    signExIn    = sx;
    M_In        = 1'($urandom);
    WB_In       = 2'b10;
    PC_In       = $urandom;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {27'd0, validOut, M_Out, WB_Out}, 0);
    chk({tag, "_dst"}, 32'(dstOut), 0);
    chk({tag, "_res"}, aluResOut, 0);
    chk({tag, "_sd"}, storeDataOut, 0);
    chk({tag, "_pc"}, PC_Out, 0);
  endtask

  task automatic exec(output logic [31:0] res);
    logic [31:0] a, bf, b, e;
    int n;
    a  = ref_fwd(src1In, readData1In);
    bf = ref_fwd(src2In, readData2In);
    b  = aluSrcIn ? signExIn : bf;
    e  = ref_alu(EXE_In, a, b);
    #1;
    if (EXE_In == 3'b111) begin
      n = 0;
      while (stall && n < 200) begin
        @(posedge clk); #1;
        chk("bubble", {29'd0, validOut, WB_Out}, 0);
        n++;
      end
      chk("stall_cycles", n, MC + 1);
    end else begin
      chk("no_stall", 32'(stall), 0);
    end
    @(posedge clk); #1;
    chk("res", aluResOut, e);
    chk("store", storeDataOut, bf);
    chk("ctl", {28'd0, validOut, M_Out, WB_Out}, {28'd0, 1'b1, M_In, WB_In});
    chk("dst", 32'(dstOut), 32'(dstIn));
    chk("pc", PC_Out, PC_In);
    m_v   = 1'b1;
    m_wb  = WB_In;
    m_dst = dstIn;
    m_res = e;
    res   = e;
  endtask

  task automatic idle();
    validIn = 1'b0;
    @(posedge clk); #1;
    chk("idle_valid", 32'(validOut), 0);
    m_v = 0; m_wb = 0; m_dst = 0; m_res = 0;
  endtask

  initial begin
    rst = 1'b0; wbWe = 0; wbDst = 0; wbData = 0;
    m_v = 0; m_wb = 0; m_dst = 0; m_res = 0;
    for (int i = 0; i < 2; i++) begin
      drive(3'(7 - i), 1'($urandom), 5'($urandom), 5'($urandom),
            5'($urandom), $urandom, $urandom, $urandom);
      wbWe = 1'($urandom); wbDst = 5'($urandom); wbData = $urandom;
      #1 chk("rst_stall", 32'(stall), 0);
      @(posedge clk); #1;
      chk_zero("rst");
    end
    rst = 1'b1; wbWe = 0;
    idle();

    drive(0, 0, 1, 2, 3, 5, 7, 0);
    exec(r);
    chk("add_5_7", r, 12);
    drive(1, 1, 3, 0, 4, 0, 0, 2);
    exec(r);
`ifdef EXE_FWD_EN
    chk("sub_fwd", r, 10);
`else
    chk("sub_fwd", r, 32'hFFFF_FFFE);
`endif

    drive(0, 0, 1, 2, 3, 5, 7, 0);
    exec(r);
    drive(3, 1, 3, 0, 6, 1, 0, 0);
    wbWe = 1; wbDst = 3; wbData = 99;
    exec(r);
`ifdef EXE_FWD_EN
    chk("prio_exm", r, 12);
`else
    chk("prio_exm", r, 1);
`endif
    drive(3, 1, 0, 0, 7, 20, 0, 0);
    wbWe = 1; wbDst = 0; wbData = 99;
    exec(r);
    chk("r0_nofwd", r, 20);
    wbWe = 0; wbDst = 0;

    drive(7, 0, 5, 6, 8, 32'hFFFF_FFFF, 3, 0);
    exec(r);
    chk("mul_ff_3", r, 32'hFFFF_FFFD);

    drive(7, 0, 9, 10, 11, 123, 456, 0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0; validIn = 1'b0;
    @(posedge clk); #1;
    chk_zero("rst_mul");
    chk("rst_mul_stall", 32'(stall), 0);
    rst = 1'b1;
    m_v = 0; m_wb = 0; m_dst = 0; m_res = 0;
    drive(0, 0, 0, 0, 12, 1, 1, 0);
    exec(r);
    chk("add_1_1", r, 2);

    drive(5, 0, 13, 14, 15, 32'hFFFF_FFFF, 1, 0);
    exec(r);
    chk("slt", r, 1);
    drive(6, 1, 13, 0, 15, 1, 0, 33);
    exec(r);
    chk("sll33", r, 2);
    drive(0, 1, 13, 0, 15, 32'h10, 0, 32'hFFFF_FFF0);
    exec(r);
    chk("add_imm", r, 0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      op = 3'($urandom);
      if (op == 3'b111 && $urandom_range(0, 2) != 0) op = 3'b000;
      drive(op, 1'($urandom), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom, $urandom, $urandom);
      WB_In  = 2'($urandom);
      wbWe   = 1'($urandom);
      wbDst  = 5'($urandom_range(0, 3));
      wbData = $urandom;
      exec(r);
      if ($urandom_range(0, 4) == 0) idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
